pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and instruction-fetch sequencer for the single-cycle RISC-V core. It sits at the consuming end of the branch-decision path and takes the `pcsrc` select produced by the branch/zero gate. It fetches each instruction over a ready-handshaked instruction-memory port and presents it to the core for exactly one execute cycle. It then advances the PC to either PC+4 or the branch target, flags misaligned branch targets, and counts retired instructions.

## Interface
Parameters:
- `XLEN`, 32, datapath/address width
- `RESET_VECTOR`, 32'h0000_0000, PC value loaded on reset

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `pcsrc`  in  1  branch-taken select (branch & zero); sampled only in EXEC
- `imm_ext`  in  XLEN  sign-extended branch offset, sampled with `pcsrc`
- `hold`  in  1  core stall request; sampled only in EXEC
- `imem_ready`  in  1  instruction memory response valid
- `imem_rdata`  in  32  instruction word from memory
- `imem_req`  out  1  fetch request
- `imem_addr`  out  XLEN  fetch address, equal to `pc`
- `instr`  out  32  registered instruction under execution
- `instr_valid`  out  1  high in EXEC only
- `pc`  out  XLEN  current PC
- `pc_plus4`  out  XLEN  `pc + 4`, combinational, for link/writeback
- `misaligned`  out  1  sticky fault flag
- `instret`  out  32  retired-instruction counter

## Operation
- States: BOOT, REQ, EXEC, TRAP.
- **BOOT** (entered on reset):
  - `imem_req` is 0.
  - Unconditionally moves to REQ on the next cycle.
- **REQ**:
  - `imem_req` is 1 and `imem_addr` equals `pc`.
  - While `imem_ready` is 0, stays in REQ; address and request are held stable.
  - When `imem_ready` is 1, captures `imem_rdata` into `instr` and moves to EXEC.
- **EXEC**:
  - `instr_valid` is 1 and `imem_req` is 0.
  - If `hold` is 1: stays in EXEC; `pc`, `instr` and `instret` are unchanged.
  - If `hold` is 0:
    - next_pc = `pcsrc` ? `pc + imm_ext` : `pc + 4`.
    - If `pcsrc` is 1 and target[1:0] ≠ 0: `pc` is not updated, `misaligned` is set to 1, `instret` does not increment, and the block moves to TRAP.
    - Otherwise: `pc` ← next_pc, `instret` += 1, and the block moves to REQ.
- **TRAP**:
  - `imem_req` = 0 and `instr_valid` = 0.
  - `pc` is frozen at the faulting branch's address.
  - Only `reset` exits TRAP.
- Arithmetic:
  - All PC sums are modulo 2^XLEN: 0xFFFF_FFFC + 4 = 0x0000_0000, with no flag raised.
  - `imm_ext` is treated as two's complement, so a negative offset branches backward.
  - `instret` wraps from 0xFFFF_FFFF to 0.
- `pcsrc`, `imm_ext` and `hold` are ignored outside EXEC.
- `imem_ready` is ignored outside REQ, and any stray response is discarded.
- Simultaneous `hold` = 1 and `pcsrc` = 1 with a misaligned target: `hold` wins; no fault is raised until the first non-held EXEC cycle.

## Timing
- Reset values, one cycle after `reset` is high:
  - `pc` = RESET_VECTOR, `imem_addr` = RESET_VECTOR, `pc_plus4` = RESET_VECTOR+4
  - `imem_req` = 0, `instr` = 0, `instr_valid` = 0, `misaligned` = 0, `instret` = 0, state = BOOT
- Reset mid-operation (any state, including REQ with `imem_req` high): the next cycle shows reset values. A memory response in that cycle is discarded.
- Minimum instruction period is 2 cycles: REQ with `imem_ready` = 1, then EXEC.
- Each memory wait cycle adds 1 cycle; each `hold` cycle adds 1 cycle.
- `instr` and `instr_valid` are registered. `instr_valid` rises the cycle after the accepting `imem_ready` edge.
- New `pc` is visible on `imem_addr` in the cycle immediately after EXEC; there is no bubble.
- `misaligned` rises the cycle after the faulting EXEC and remains high until reset.

## Test plan
- **Reset/boot:** RESET_VECTOR=0x100, `reset` 1 for 2 cycles, `imem_ready` held 1 → BOOT for 1 cycle; `imem_addr` = 0x100 with `imem_req` = 1; first `instr_valid` pulse 2 cycles after BOOT.
- **Sequential fetch with wait states:** `pcsrc` = 0, `imem_ready` low for 3 cycles per request → addresses 0x100, 0x104, 0x108; `imem_addr` stable throughout each wait; `instret` = 3 after three EXECs.
- **Taken branches:**
  - At pc = 0x108, `pcsrc` = 1, `imm_ext` = 0xFFFF_FFF8 → next `imem_addr` = 0x100.
  - With `imm_ext` = 0x20 → 0x128.
  - `pcsrc` = 1 in REQ is ignored.
- **Hold:** `hold` = 1 for 4 EXEC cycles with `pcsrc` = 1 → `instr_valid` stays high 5 cycles; `pc` and `instret` unchanged until release; a single branch is taken on release.
- **Misaligned target:** pc = 0x100, `pcsrc` = 1, `imm_ext` = 0x6 → `misaligned` = 1 next cycle; `pc` stays 0x100; `imem_req` stays 0 for 10 cycles; `instret` unchanged; `reset` clears all.
- **Wrap and mid-fetch reset:**
  - pc = 0xFFFF_FFFC with `pcsrc` = 0 → pc = 0x0.
  - `reset` asserted in REQ with `imem_ready` = 1 in the same cycle → `instr` = 0, `instret` = 0, and the state is BOOT.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch sequencer.
// Fetches one instruction over a ready-handshaked memory port, holds it for
// a single execute cycle (extendable by hold), then advances the PC to
// PC+4 or the branch target. A misaligned branch target freezes the unit
// in TRAP until reset.
//
// Handshake: imem_req is a request-valid. While imem_req is high, imem_addr
// is held stable until the memory answers with imem_ready; the word on
// imem_rdata is accepted on the rising edge where imem_req and imem_ready
// are both high. imem_ready in any other cycle is ignored.
module pc_fetch_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pcsrc,
    input  logic [XLEN-1:0] imm_ext,
    input  logic            hold,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned,
    output logic [31:0]     instret,
    output logic [1:0]      dbg_state
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        EXEC = 2'd2,
        TRAP = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] next_pc;
    logic            fault;
    logic            advance;

    assign imem_addr = pc;
    assign pc_plus4  = pc + XLEN'(4);
    assign dbg_state = state;

    // Next-PC selection, fault detection and next-state decode
    always_comb begin
        branch_target = pc + imm_ext;
        next_pc       = pcsrc ? branch_target : pc_plus4;
        fault         = 1'b0;
        advance       = 1'b0;
        state_next    = state;
        case (state)
            BOOT: state_next = REQ;
            REQ: begin
                if (imem_ready) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (!hold) begin
                    if (pcsrc && (branch_target[1:0] != 2'b00)) begin
                        fault      = 1'b1;
                        state_next = TRAP;
                    end else begin
                        advance    = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            TRAP: state_next = TRAP;
            default: state_next = BOOT;
        endcase
    end

    // State, PC, instruction latch, retire counter and registered strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_VECTOR;
            instr       <= 32'd0;
            instret     <= 32'd0;
            misaligned  <= 1'b0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_next;
            imem_req    <= (state_next == REQ);
            instr_valid <= (state_next == EXEC);
            if ((state == REQ) && imem_ready) begin
                instr <= imem_rdata;
            end
            if (advance) begin
                pc      <= next_pc;
                instret <= instret + 32'd1;
            end
            if (fault) begin
                misaligned <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: memory/branch driver tasks, a queue of expected
// instruction words, and a bench-side PC / retire-count model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RV = 32'h0000_0100;
    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_TRAP = 2'd3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pcsrc = 1'b0;
    logic [31:0] imm_ext = 32'd0;
    logic        hold = 1'b0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        misaligned;
    logic [31:0] instret;
    logic [1:0]  dbg_state;

    logic [31:0] exp_q[$];
    logic [31:0] model_pc;
    logic [31:0] model_instret;
    int          n_checks = 0;
    int          n_errors = 0;

    pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset), .pcsrc(pcsrc), .imm_ext(imm_ext),
        .hold(hold), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .imem_req(imem_req), .imem_addr(imem_addr), .instr(instr),
        .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
        .misaligned(misaligned), .instret(instret), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Outputs are sampled and inputs changed on the falling edge.
    task automatic check_reset_values();
        check("rst_state", 32'(dbg_state), 32'(S_BOOT));
        check("rst_pc", pc, RV);
        check("rst_addr", imem_addr, RV);
        check("rst_pc4", pc_plus4, RV + 32'd4);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_mis", 32'(misaligned), 32'd0);
        check("rst_instret", instret, 32'd0);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        check_reset_values();
        reset = 1'b0;
        model_pc = RV;
        model_instret = 32'd0;
        exp_q.delete();
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("req_timeout", 32'd0, 32'd1);
    endtask

    // One full instruction: wait states, accept, hold cycles, then retire.
    task automatic do_instr(input int waits, input logic br, input logic [31:0] imm,
                            input int holds);
        bit          ok;
        logic [31:0] word;
        logic [31:0] target;
        wait_req(ok);
        if (!ok) return;
        check("req_addr", imem_addr, model_pc);
        for (int w = 0; w < waits; w++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            pcsrc      = 1'b1;               // ignored outside EXEC
            imm_ext    = $urandom_range(1, 3);
            @(negedge clk);
            check("wait_req", 32'(imem_req), 32'd1);
            check("wait_addr", imem_addr, model_pc);
        end
        word       = $urandom;
        imem_ready = 1'b1;
        imem_rdata = word;
        pcsrc      = 1'b0;
        exp_q.push_back(word);
        @(negedge clk);
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        check("exec_valid", 32'(instr_valid), 32'd1);
        check("exec_req", 32'(imem_req), 32'd0);
        if (exp_q.size() > 0) check("instr", instr, exp_q.pop_front());
        pcsrc   = br;
        imm_ext = imm;
        for (int h = 0; h < holds; h++) begin
            hold = 1'b1;
            @(negedge clk);
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_pc", pc, model_pc);
            check("hold_instret", instret, model_instret);
            check("hold_mis", 32'(misaligned), 32'd0);
        end
        hold   = 1'b0;
        target = br ? model_pc + imm : model_pc + 32'd4;
        @(negedge clk);
        pcsrc   = 1'b0;
        imm_ext = 32'd0;
        if (br && (target[1:0] != 2'b00)) begin
            check("trap_mis", 32'(misaligned), 32'd1);
            check("trap_state", 32'(dbg_state), 32'(S_TRAP));
            check("trap_pc", pc, model_pc);
            check("trap_instret", instret, model_instret);
        end else begin
            model_pc = target;
            model_instret = model_instret + 32'd1;
            check("next_addr", imem_addr, model_pc);
            check("next_req", 32'(imem_req), 32'd1);
            check("instret", instret, model_instret);
            check("pc_plus4", pc_plus4, model_pc + 32'd4);
        end
    endtask

    initial begin
        model_pc = RV;
        model_instret = 32'd0;
        // reset / boot with imem_ready held high
        imem_ready = 1'b1;
        do_reset(2);
        @(negedge clk);
        check("boot_req", 32'(imem_req), 32'd1);
        check("boot_addr", imem_addr, RV);
        check("boot_state", 32'(dbg_state), 32'(S_REQ));
        do_instr(0, 1'b0, 32'd0, 0);                 // 0x100 -> 0x104
        // sequential with wait states, then backward branch from 0x108
        do_instr(3, 1'b0, 32'd0, 0);                 // 0x104 -> 0x108
        do_instr(3, 1'b1, 32'hFFFF_FFF8, 0);         // 0x108 -> 0x100
        check("instret3", instret, 32'd3);
        // forward branch from 0x108
        do_instr(1, 1'b0, 32'd0, 0);                 // 0x100 -> 0x104
        do_instr(0, 1'b0, 32'd0, 0);                 // 0x104 -> 0x108
        do_instr(2, 1'b1, 32'h0000_0020, 0);         // 0x108 -> 0x128
        // held branch, taken once on release, lands at the top of memory
        do_instr(0, 1'b1, 32'hFFFF_FFFC - 32'h128, 4); // 0x128 -> 0xFFFFFFFC
        do_instr(1, 1'b0, 32'd0, 0);                 // wrap -> 0x0
        check("wrap_mis", 32'(misaligned), 32'd0);
        do_instr(0, 1'b1, 32'h0000_0100, 0);         // 0x0 -> 0x100
        // reset during REQ with a response in the same cycle
        reset      = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_reset_values();
        reset      = 1'b0;
        imem_ready = 1'b0;
        model_pc = RV;
        model_instret = 32'd0;
        exp_q.delete();
        // misaligned target, held one cycle first
        do_instr(0, 1'b1, 32'h0000_0006, 1);
        for (int i = 0; i < 10; i++) begin
            imem_ready = 1'($urandom_range(0, 1));
            pcsrc      = 1'($urandom_range(0, 1));
            imm_ext    = $urandom;
            @(negedge clk);
            check("trap_req", 32'(imem_req), 32'd0);
            check("trap_valid", 32'(instr_valid), 32'd0);
            check("trap_hold_pc", pc, RV);
        end
        check("trap_keep_mis", 32'(misaligned), 32'd1);
        check("trap_keep_instret", instret, 32'd0);
        pcsrc = 1'b0;
        imem_ready = 1'b0;
        do_reset(1);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Overall time bound
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
